// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies LEN bytes from page {src_q, 8'h00} into OAM,
// one byte per M-cycle strobe, after START_DELAY strobes of set-up time.
// While a transfer runs it owns the source bus and the OAM write port.
module oam_dma_ctrl #(
  parameter int unsigned LEN         = 160,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        c_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        start_i,
  input  logic [7:0]  src_hi_i,
  output logic        rd_req_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic        oam_we_o,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_wdata_o,
  output logic        busy_o,
  output logic        cpu_bus_block_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  // Last byte index of a transfer; LEN=256 gives 8'hFF so idx wraps to 0.
  localparam logic [7:0] LAST_IDX = 8'(LEN - 32'd1);
  // Delay count value on which the final set-up strobe lands.
  localparam logic [3:0] DLY_LAST = 4'(START_DELAY - 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        oam_we_q, oam_we_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_wdata_q, oam_wdata_d;

  // Pages E0..FF mirror C0..DF (echo RAM), so the source is folded down.
  function automatic logic [7:0] fold_src(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  // Next-state logic: a start strobe overrides everything, else step on ce.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    dcnt_d      = dcnt_q;
    oam_we_d    = 1'b0;
    oam_addr_d  = oam_addr_q;
    oam_wdata_d = oam_wdata_q;
    if (start_i) begin
      // A step coinciding with a (re)start is dropped on purpose.
      src_d   = fold_src(src_hi_i);
      idx_d   = 8'd0;
      dcnt_d  = 4'd0;
      state_d = (START_DELAY == 32'd0) ? ST_XFER : ST_DELAY;
    end else if (ce_i) begin
      case (state_q)
        ST_DELAY: begin
          dcnt_d = dcnt_q + 4'd1;
          if (dcnt_q == DLY_LAST) begin
            state_d = ST_XFER;
          end else begin
            state_d = ST_DELAY;
          end
        end
        ST_XFER: begin
          oam_wdata_d = rd_data_i;
          oam_addr_d  = idx_q;
          oam_we_d    = 1'b1;
          idx_d       = idx_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_XFER;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      // No strobe: hold everything so a stalled transfer stays frozen.
      state_d = state_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge c_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      src_q       <= 8'd0;
      idx_q       <= 8'd0;
      dcnt_q      <= 4'd0;
      oam_we_q    <= 1'b0;
      oam_addr_q  <= 8'd0;
      oam_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      dcnt_q      <= dcnt_d;
      oam_we_q    <= oam_we_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
    end
  end

  // Bus and status outputs decoded from registered state only.
  always_comb begin
    rd_req_o        = (state_q == ST_XFER);
    rd_addr_o       = {src_q, idx_q};
    busy_o          = (state_q != ST_IDLE) | oam_we_q;
    cpu_bus_block_o = (state_q == ST_XFER) | oam_we_q;
  end

  assign oam_we_o    = oam_we_q;
  assign oam_addr_o  = oam_addr_q;
  assign oam_wdata_o = oam_wdata_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: one LEN=160/START_DELAY=1 instance and
// one LEN=256/START_DELAY=0 instance share stimulus; sel picks the observed one.
module tb_oam_dma_ctrl;

  logic        c = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_hi = 8'h00;
  logic        sel = 1'b0;

  logic        a_rd_req, a_oam_we, a_busy, a_blk;
  logic [15:0] a_rd_addr;
  logic [7:0]  a_rd_data, a_oam_addr, a_oam_wdata;
  logic        b_rd_req, b_oam_we, b_busy, b_blk;
  logic [15:0] b_rd_addr;
  logic [7:0]  b_rd_data, b_oam_addr, b_oam_wdata;

  logic        m_rd_req, m_oam_we, m_busy, m_blk;
  logic [15:0] m_rd_addr;
  logic [7:0]  m_oam_addr, m_oam_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  logic [7:0] exp_src  = 8'h00;
  logic [7:0] exp_idx  = 8'h00;
  logic [7:0] next_src = 8'h00;
  logic [7:0] last_addr = 8'h00;

  // Source memory contents: a simple address hash.
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'hA5;
  endfunction

  assign a_rd_data = memf(a_rd_addr);
  assign b_rd_data = memf(b_rd_addr);

  assign m_rd_req    = sel ? b_rd_req    : a_rd_req;
  assign m_rd_addr   = sel ? b_rd_addr   : a_rd_addr;
  assign m_oam_we    = sel ? b_oam_we    : a_oam_we;
  assign m_oam_addr  = sel ? b_oam_addr  : a_oam_addr;
  assign m_oam_wdata = sel ? b_oam_wdata : a_oam_wdata;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_blk       = sel ? b_blk       : a_blk;

  oam_dma_ctrl #(.LEN(160), .START_DELAY(1)) dut_a (
    .c_i(c), .reset_i(reset), .ce_i(ce), .start_i(start), .src_hi_i(src_hi),
    .rd_req_o(a_rd_req), .rd_addr_o(a_rd_addr), .rd_data_i(a_rd_data),
    .oam_we_o(a_oam_we), .oam_addr_o(a_oam_addr), .oam_wdata_o(a_oam_wdata),
    .busy_o(a_busy), .cpu_bus_block_o(a_blk)
  );

  oam_dma_ctrl #(.LEN(256), .START_DELAY(0)) dut_b (
    .c_i(c), .reset_i(reset), .ce_i(ce), .start_i(start), .src_hi_i(src_hi),
    .rd_req_o(b_rd_req), .rd_addr_o(b_rd_addr), .rd_data_i(b_rd_data),
    .oam_we_o(b_oam_we), .oam_addr_o(b_oam_addr), .oam_wdata_o(b_oam_wdata),
    .busy_o(b_busy), .cpu_bus_block_o(b_blk)
  );

  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive at negedge, observe writes 1 time unit after posedge.
  task automatic tick(input logic ce_v, input logic st_v, input logic rst_v);
    @(negedge c);
    ce = ce_v;
    start = st_v;
    reset = rst_v;
    if (ce_v && m_rd_req && !rst_v) begin
      check("rd_addr", 32'(m_rd_addr), 32'({exp_src, exp_idx}));
    end
    @(posedge c);
    #1;
    if (m_oam_we) begin
      check("oam_addr", 32'(m_oam_addr), 32'(exp_idx));
      check("oam_wdata", 32'(m_oam_wdata), 32'(memf({exp_src, exp_idx})));
      last_addr = m_oam_addr;
      exp_idx = exp_idx + 8'd1;
      wr_cnt++;
    end
    if (st_v) begin
      exp_src = next_src;
      exp_idx = 8'd0;
      wr_cnt = 0;
    end
  endtask

  task automatic period();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic start_xfer(input logic [7:0] s, input logic [7:0] folded, input logic with_ce);
    src_hi = s;
    next_src = folded;
    tick(with_ce, 1'b1, 1'b0);
  endtask

  task automatic run_to_idle();
    int n = 0;
    while (m_busy && n < 600) begin
      period();
      n++;
    end
    check("run_idle", 32'(m_busy), 32'd0);
  endtask

  task automatic run_to_cnt(input int k);
    int n = 0;
    while (wr_cnt < k && n < 600) begin
      period();
      n++;
    end
    check("run_cnt", 32'(wr_cnt), 32'(k));
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_rd_req", 32'(m_rd_req), 32'd0);
    check("rst_we", 32'(m_oam_we), 32'd0);
    check("rst_blk", 32'(m_blk), 32'd0);
    check("rst_oam_addr", 32'(m_oam_addr), 32'd0);
    check("rst_oam_wdata", 32'(m_oam_wdata), 32'd0);

    // Full transfer from C1 with start-delay timing
    start_xfer(8'hC1, 8'hC1, 1'b0);
    check("st_busy", 32'(m_busy), 32'd1);
    check("st_rd_req", 32'(m_rd_req), 32'd0);
    check("st_blk", 32'(m_blk), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    check("dly_rd_req", 32'(m_rd_req), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("x1_rd_req", 32'(m_rd_req), 32'd1);
    check("x1_rd_addr", 32'(m_rd_addr), 32'h0000_C100);
    check("x1_we", 32'(m_oam_we), 32'd0);
    check("x1_blk", 32'(m_blk), 32'd1);
    period();
    check("first_we", 32'(m_oam_we), 32'd1);
    check("first_cnt", 32'(wr_cnt), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("we_pulse", 32'(m_oam_we), 32'd0);
    run_to_idle();
    check("t1_cnt", 32'(wr_cnt), 32'd160);
    check("t1_last", 32'(last_addr), 32'd159);
    check("t1_rd_req", 32'(m_rd_req), 32'd0);
    check("t1_blk", 32'(m_blk), 32'd0);

    // Source folding, including restart while busy
    start_xfer(8'hFE, 8'hDE, 1'b0);
    period();
    check("fold_fe", 32'(m_rd_addr), 32'h0000_DE00);
    start_xfer(8'hDF, 8'hDF, 1'b0);
    period();
    check("fold_df", 32'(m_rd_addr), 32'h0000_DF00);
    do_reset();

    // Restart at idx 50 coincident with ce
    start_xfer(8'hC1, 8'hC1, 1'b0);
    run_to_cnt(50);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    start_xfer(8'h80, 8'h80, 1'b1);
    check("rs_we", 32'(m_oam_we), 32'd0);
    check("rs_rd_req", 32'(m_rd_req), 32'd0);
    check("rs_busy", 32'(m_busy), 32'd1);
    period();
    check("rs_addr", 32'(m_rd_addr), 32'h0000_8000);
    run_to_idle();
    check("rs_cnt", 32'(wr_cnt), 32'd160);

    // Reset mid-transfer aborts
    start_xfer(8'h40, 8'h40, 1'b0);
    run_to_cnt(10);
    tick(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    check("ab_busy", 32'(m_busy), 32'd0);
    check("ab_rd_req", 32'(m_rd_req), 32'd0);
    check("ab_we", 32'(m_oam_we), 32'd0);
    for (int i = 0; i < 10; i++) period();
    check("ab_cnt", 32'(wr_cnt), 32'd10);
    check("ab_idle", 32'(m_busy), 32'd0);

    // ce stall mid-transfer then resume
    start_xfer(8'h30, 8'h30, 1'b0);
    run_to_cnt(20);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0);
    check("stall_cnt", 32'(wr_cnt), 32'd20);
    check("stall_addr", 32'(m_rd_addr), 32'h0000_3014);
    check("stall_rd_req", 32'(m_rd_req), 32'd1);
    run_to_idle();
    check("stall_total", 32'(wr_cnt), 32'd160);

    // LEN=256, START_DELAY=0 instance
    sel = 1'b1;
    start_xfer(8'h12, 8'h12, 1'b0);
    check("b_rd_req", 32'(m_rd_req), 32'd1);
    check("b_rd_addr", 32'(m_rd_addr), 32'h0000_1200);
    check("b_busy", 32'(m_busy), 32'd1);
    period();
    check("b_first_we", 32'(m_oam_we), 32'd1);
    run_to_idle();
    check("b_cnt", 32'(wr_cnt), 32'd256);
    check("b_last", 32'(last_addr), 32'h0000_00FF);
    check("b_rd_req_end", 32'(m_rd_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
